rom_scanner: RTL and testbench
==============================

// Module: rom_scanner
// PURPOSE
//  Upstream sequencer for the 16x4 rom: on a start pulse it sweeps a programmable
//  address range, drives rom read/address and captures each rom data word after the
//  rom read latency. Each word is presented with its address on a valid/ready stream.
//  One read is outstanding at a time. Feeds dump/compare logic that consumes rom contents.
// PARAMETERS
//  AW      4  rom address width; range wraps modulo 2**AW
//  DW      4  rom data width
//  RD_LAT  1  clk edges from rom sampling read/address to data_out stable (>=1)
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous active-high reset
//  start        in   1   sweep request; sampled only in IDLE
//  abort        in   1   synchronous cancel of a sweep in progress
//  first_addr   in   AW  sweep start address, latched when start is accepted
//  last_addr    in   AW  sweep end address (inclusive), latched when start is accepted
//  rom_read     out  1   read strobe to rom
//  rom_address  out  AW  address to rom
//  rom_data     in   DW  rom data_out
//  out_valid    out  1   out_data/out_addr hold a captured word
//  out_ready    in   1   consumer accepts the word when out_valid&&out_ready at posedge
//  out_data     out  DW  captured rom word
//  out_addr     out  AW  address the word was read from
//  busy         out  1   sweep in progress
//  done         out  1   one-cycle pulse after final word transferred or after abort
// BEHAVIOUR
//  Reset: state=IDLE; rom_read, out_valid, busy and done are 0;
//   rom_address, out_data and out_addr are 0. Reset wins over all other inputs.
//  States: IDLE, ISSUE, WAIT, HOLD, DONE.
//  IDLE: if start=1, latch first/last, cur<=first_addr, go to ISSUE.
//   busy rises in the next cycle.
//  ISSUE (1 cycle): rom_read=1, rom_address=cur. rom_read is 0 in every other state.
//   rom_address holds its last value outside ISSUE. Then go to WAIT, lat_cnt<=0.
//  WAIT: lat_cnt increments each cycle. In the cycle with lat_cnt==RD_LAT-1, at that
//   cycle's posedge: out_data<=rom_data, out_addr<=cur, out_valid<=1, go to HOLD.
//   out_valid first rises RD_LAT+1 cycles after the cycle rom_read was high.
//  HOLD: out_data/out_addr/out_valid stay stable while out_ready=0; no timeout.
//   On a posedge with out_ready=1: out_valid<=0.
//   If cur==last, go to DONE; otherwise cur<=cur+1 (mod 2**AW) and go to ISSUE.
//   The next rom_read follows the transfer by 1 cycle.
//  DONE (1 cycle): done=1, busy=0; go to IDLE. A start in DONE is ignored.
//  busy=1 in ISSUE, WAIT and HOLD; busy=0 in IDLE and DONE.
//  Word count = ((last-first) mod 2**AW)+1.
//   first==last gives 1 word. last<first wraps through 2**AW-1 to 0.
//   first=0 with last=2**AW-1 gives all 16 words.
//  start while busy is ignored, and first/last are not re-latched.
//  abort=1 in ISSUE, WAIT or HOLD: next state is DONE; out_valid<=0; a pending
//   word is dropped even if out_ready=1 in the same cycle.
//   abort in IDLE or DONE has no effect.
//  rom_data is ignored outside the capture edge.
// TESTING
//  1 rst high 3 cycles -> all outputs 0, state IDLE; start during rst ignored.
//  2 start, first=0, last=15, out_ready=1 -> 16 words out_addr 0..15 matching the
//    rom model, each word RD_LAT+2 cycles apart; done pulses once; busy low after.
//  3 first=14, last=1 -> out_addr sequence 14,15,0,1 (wrap); done after 4th transfer.
//  4 first=last=5, out_ready held 0 for 10 cycles -> out_valid and out_data stable,
//    no further rom_read; ready=1 -> single transfer, then done.
//  5 abort during HOLD of addr 3 (range 0..9), with out_ready=1 -> no transfer of
//    addr 3, done next cycle, rom_read stays 0; a new start then restarts at first_addr.
//  6 rst asserted mid-WAIT -> next cycle IDLE, out_valid=0, busy=0, no done pulse;
//    start pulse while busy -> ignored, sweep range unchanged.

Source files
------------

// File: rtl/rom_scanner.sv
// rom_scanner
//   Sequencer that sweeps an inclusive, wrapping address range of a small
//   synchronous rom, one read outstanding at a time. Each captured rom word is
//   offered with its address on a valid/ready stream; a done pulse marks the
//   end of a sweep (normal completion or abort).
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   start        sweep request, honoured only while idle
//   abort        cancel a sweep in progress
//   first_addr   sweep start address, captured with start
//   last_addr    sweep end address (inclusive), captured with start
//   rom_read     read strobe to the rom
//   rom_address  address to the rom
//   rom_data     rom data output
//   out_valid    out_data/out_addr hold a captured word
//   out_ready    consumer accepts the word when out_valid && out_ready
//   out_data     captured rom word
//   out_addr     address the word was read from
//   busy         sweep in progress
//   done         one-cycle pulse after the final transfer or after an abort
module rom_scanner #(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic          rom_read,
  output logic [AW-1:0] rom_address,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Latency counter only needs to reach RD_LAT-1.
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [AW-1:0] cur_r;
  logic [AW-1:0] cur_next_s;
  logic [AW-1:0] last_r;
  logic [LW-1:0] lat_cnt_r;
  logic          lat_hit_s;
  logic          at_last_s;
  logic          rom_read_r;
  logic [AW-1:0] rom_address_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic [AW-1:0] out_addr_r;
  logic          busy_r;
  logic          done_r;

  assign lat_hit_s = (lat_cnt_r == LW'(RD_LAT - 1));
  assign at_last_s = (cur_r == last_r);

  // Next-state decode; abort outranks every other event while a sweep runs.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_ISSUE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          next_state_s = S_DONE;
        end else if (lat_hit_s) begin
          next_state_s = S_HOLD;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (abort) begin
          next_state_s = S_DONE;
        end else if (out_ready) begin
          if (at_last_s) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_ISSUE;
          end
        end else begin
          next_state_s = S_HOLD;
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Sweep pointer for the next cycle; lets rom_address be registered together with entry into ISSUE.
  always_comb begin
    cur_next_s = cur_r;
    if ((state_r == S_IDLE) && start) begin
      cur_next_s = first_addr;
    end else if ((state_r == S_HOLD) && !abort && out_ready && !at_last_s) begin
      cur_next_s = cur_r + AW'(1);
    end else begin
      cur_next_s = cur_r;
    end
  end

  // State register and the status outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      rom_read_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      rom_read_r <= (next_state_s == S_ISSUE);
      busy_r     <= (next_state_s == S_ISSUE) || (next_state_s == S_WAIT) ||
                    (next_state_s == S_HOLD);
      done_r     <= (next_state_s == S_DONE);
    end
  end

  // Sweep range, current pointer and the rom address that holds outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r         <= {AW{1'b0}};
      last_r        <= {AW{1'b0}};
      rom_address_r <= {AW{1'b0}};
    end else begin
      cur_r <= cur_next_s;
      if ((state_r == S_IDLE) && start) begin
        last_r <= last_addr;
      end
      if (next_state_s == S_ISSUE) begin
        rom_address_r <= cur_next_s;
      end
    end
  end

  // Read latency counter, restarted every time a read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if (state_r == S_ISSUE) begin
      lat_cnt_r <= {LW{1'b0}};
    end else if (state_r == S_WAIT) begin
      lat_cnt_r <= lat_cnt_r + LW'(1);
    end
  end

  // Output stream: capture on the final latency edge, release on transfer or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_addr_r  <= {AW{1'b0}};
    end else begin
      case (state_r)
        S_WAIT: begin
          if (!abort && lat_hit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rom_data;
            out_addr_r  <= cur_r;
          end
        end
        S_HOLD: begin
          // A word pending during abort is dropped, never transferred.
          if (abort || out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign rom_read    = rom_read_r;
  assign rom_address = rom_address_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_addr    = out_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_rom_scanner.sv
module tb_rom_scanner;
  localparam int AW     = 4;
  localparam int DW     = 4;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          rom_read;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  rom_scanner #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rom_read(rom_read), .rom_address(rom_address), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 16x4 rom model with RD_LAT-edge read latency; output holds between reads.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (rom_read) pipe[0] <= mem[rom_address];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_data = pipe[RD_LAT-1];

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    int         words;
    int         rdy_mode;   // 0: always ready, 1: random ready
    bit         interfere;  // pulse start with another range mid-sweep
  } sweep_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Run one sweep and check it against the word list derived from the range rule.
  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int words,
                           input int rdy_mode, input bit interfere);
    int  exp_q[$];
    int  rd_q[$];
    int  a;
    int  n_xfer;
    int  last_xfer;
    int  first_valid;
    bit  seen_done;
    a = f;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(a);
      if (a == l) break;
      a = (a + 1) % 16;
    end
    rd_q = exp_q;
    n_xfer = 0; last_xfer = -1; first_valid = -1; seen_done = 1'b0;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = (rdy_mode == 0);
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        chk("done_busy_low", busy, 0);
        chk("word_count", n_xfer, words);
        chk("all_words_seen", exp_q.size(), 0);
        break;
      end
      if (rom_read) begin
        if (rd_q.size() == 0) chk("extra_rom_read", 1, 0);
        else chk("rom_address", rom_address, rd_q.pop_front());
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (rdy_mode == 0) chk("first_latency", cyc, RD_LAT + 2);
      end
      start = interfere && (cyc == 2);
      if (interfere && cyc == 2) begin
        first_addr = ~f; last_addr = ~l;
      end
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_transfer", 1, 0);
        end else begin
          a = exp_q.pop_front();
          chk("out_addr", out_addr, a);
          chk("out_data", out_data, mem[a]);
        end
        if (rdy_mode == 0 && last_xfer >= 0) chk("word_spacing", cyc - last_xfer, RD_LAT + 2);
        last_xfer = cyc;
        n_xfer++;
      end
      tick();
    end
    start = 1'b0;
    if (!seen_done) chk("sweep_timeout", 0, 1);
    tick();
    chk("done_single_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  sweep_t tbl [7];

  initial begin
    int n_xfer;
    bit hit;
    logic [3:0] rf, rl;

    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    tbl[0] = '{4'd0,  4'd15, 16, 0, 1'b0};
    tbl[1] = '{4'd14, 4'd1,  4,  0, 1'b0};
    tbl[2] = '{4'd5,  4'd5,  1,  1, 1'b0};
    tbl[3] = '{4'd9,  4'd3,  11, 1, 1'b0};
    tbl[4] = '{4'd2,  4'd4,  3,  0, 1'b1};
    tbl[5] = '{4'd15, 4'd0,  2,  1, 1'b0};
    tbl[6] = '{4'd7,  4'd6,  16, 1, 1'b0};

    // Reset for 3 cycles with start held high.
    rst = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    first_addr = 4'd3; last_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rom_read", rom_read, 0);
      chk("rst_rom_address", rom_address, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_read", rom_read, 0);

    // Table-driven sweeps.
    for (int i = 0; i < 7; i++)
      run_sweep(tbl[i].f, tbl[i].l, tbl[i].words, tbl[i].rdy_mode, tbl[i].interfere);

    // Randomized sweeps; word count from the modular range formula.
    for (int i = 0; i < 6; i++) begin
      rf = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      run_sweep(rf, rl, ((int'(rl) - int'(rf)) & 15) + 1, 1, 1'b0);
    end

    // Single word held with out_ready low for 10 cycles.
    first_addr = 4'd5; last_addr = 4'd5; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (out_valid) hit = 1'b1;
      else tick();
    end
    chk("hold_valid_seen", hit, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, mem[5]);
      chk("hold_addr", out_addr, 5);
      chk("hold_no_read", rom_read, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_xfer_valid_low", out_valid, 0);
    chk("hold_done", done, 1);
    tick();
    chk("hold_done_once", done, 0);
    chk("hold_busy_low", busy, 0);

    // Abort during HOLD of address 3 (range 0..9) with out_ready high.
    first_addr = 4'd0; last_addr = 4'd9; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    n_xfer = 0; hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (out_valid && out_addr == 4'd3) begin
        hit = 1'b1;
        abort = 1'b1;
      end else if (out_valid) begin
        n_xfer++;
      end
      tick();
    end
    abort = 1'b0;
    chk("abort_reached_addr3", hit, 1);
    chk("abort_prior_xfers", n_xfer, 3);
    chk("abort_done", done, 1);
    chk("abort_valid_low", out_valid, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_no_read", rom_read, 0);
    tick();
    chk("abort_done_once", done, 0);
    chk("abort_still_no_read", rom_read, 0);
    run_sweep(4'd0, 4'd9, 10, 0, 1'b0);

    // Reset in the middle of WAIT.
    first_addr = 4'd0; last_addr = 4'd15; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_read", rom_read, 0);
    tick();
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);
    chk("midrst_idle_read", rom_read, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
